// File: rtl/run_scan_pkg.sv
// rtl/run_scan_pkg.sv - shared state encoding, width helper and derived widths for the run scanner
package run_scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    localparam int DEF_WIDTH   = 16;
    localparam int DEF_RUN_LEN = 4;
    localparam int CNT_W       = clog2(DEF_WIDTH + 1);
    localparam int IDX_W       = clog2(DEF_WIDTH);

endpackage

// File: rtl/run_tracker.sv
// rtl/run_tracker.sv - serial detector flagging each bit that completes a run of RUN_LEN equal bits
module run_tracker
    import run_scan_pkg::*;
#(
    parameter  int RUN_LEN = 4,
    localparam int LEN_W   = clog2(RUN_LEN + 1)
) (
    input  logic clk,
    input  logic aclr,
    input  logic start,
    input  logic bit_in,
    input  logic en,
    output logic hit
);

    logic             prev_bit;
    logic [LEN_W-1:0] run_len;
    logic [LEN_W-1:0] len_next;

    // run_len == 0 marks "no bit seen yet", so the first bit of a word starts a run of 1
    always_comb begin
        len_next = LEN_W'(1);
        if (run_len != '0 && bit_in == prev_bit) begin
            if (run_len == LEN_W'(RUN_LEN))
                len_next = run_len;
            else
                len_next = run_len + LEN_W'(1);
        end
    end

    assign hit = en && (len_next == LEN_W'(RUN_LEN));

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            prev_bit <= 1'b0;
            run_len  <= '0;
        end else if (start) begin
            prev_bit <= 1'b0;
            run_len  <= '0;
        end else if (en) begin
            prev_bit <= bit_in;
            run_len  <= len_next;
        end
    end

endmodule

// File: rtl/run_scan_ctrl.sv
// rtl/run_scan_ctrl.sv - word-in/result-out sequencer around run_tracker
// Optional: RUN_SCAN_EARLY_EXIT_EN stops the scan at the first hit.
module run_scan_ctrl
    import run_scan_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int RUN_LEN  = 4,
    localparam int CNT_BITS = clog2(WIDTH + 1),
    localparam int IDX_BITS = clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CNT_BITS-1:0] out_count,
    output logic [IDX_BITS-1:0] out_first_idx,
    output logic                out_hit,
    output logic                busy
);

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    data;
    logic [IDX_BITS-1:0] idx;
    logic                hit;
    logic                last_bit;
    logic                scan_end;
    logic                accept;

    assign last_bit = (idx == IDX_BITS'(WIDTH - 1));
    assign accept   = (state == IDLE) && in_valid;

`ifdef RUN_SCAN_EARLY_EXIT_EN
    assign scan_end = last_bit || hit;
`else
    assign scan_end = last_bit;
`endif

    // aclr gates in_ready so nothing is offered while reset is held
    assign in_ready = (state == IDLE) && !aclr;
    assign busy     = (state == SCAN) || (state == DONE);

    run_tracker #(
        .RUN_LEN (RUN_LEN)
    ) u_tracker (
        .clk    (clk),
        .aclr   (aclr),
        .start  (accept),
        .bit_in (data[idx]),
        .en     (state == SCAN),
        .hit    (hit)
    );

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = SCAN;
            SCAN:    if (scan_end)  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // out_hit doubles as the "first hit already recorded" flag
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            data          <= '0;
            idx           <= '0;
            out_count     <= '0;
            out_first_idx <= '0;
            out_hit       <= 1'b0;
            out_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data          <= in_data;
                        idx           <= '0;
                        out_count     <= '0;
                        out_first_idx <= '0;
                        out_hit       <= 1'b0;
                    end
                end
                SCAN: begin
                    idx <= idx + IDX_BITS'(1);
                    if (hit) begin
                        out_count <= out_count + CNT_BITS'(1);
                        out_hit   <= 1'b1;
                        if (!out_hit)
                            out_first_idx <= idx;
                    end
                    if (scan_end)
                        out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready)
                        out_valid <= 1'b0;
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_run_scan_ctrl.sv
// tb/tb_run_scan_ctrl.sv - directed scoreboard bench for run_scan_ctrl
module tb_run_scan_ctrl;

    localparam int WIDTH   = 16;
    localparam int RUN_LEN = 4;

    logic        clk = 1'b0;
    logic        aclr = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [4:0]  out_count;
    logic [3:0]  out_first_idx;
    logic        out_hit;
    logic        busy;

    typedef struct {
        int count;
        int first;
        int lat;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    run_scan_ctrl #(
        .WIDTH   (WIDTH),
        .RUN_LEN (RUN_LEN)
    ) dut (
        .clk           (clk),
        .aclr          (aclr),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_count     (out_count),
        .out_first_idx (out_first_idx),
        .out_hit       (out_hit),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // window formulation: bit i hits when it and the RUN_LEN-1 bits below it are all equal
    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        bit   stop;
        bit   eq;
        e.count = 0;
        e.first = 0;
        e.lat   = WIDTH;
        stop    = 1'b0;
        for (int i = RUN_LEN - 1; i < WIDTH && !stop; i++) begin
            eq = 1'b1;
            for (int k = 1; k < RUN_LEN; k++)
                if (w[i-k] !== w[i]) eq = 1'b0;
            if (eq) begin
                if (e.count == 0) e.first = i;
                e.count++;
`ifdef RUN_SCAN_EARLY_EXIT_EN
                e.lat = i + 1;
                stop  = 1'b1;
`endif
            end
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] w);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic run_word(input logic [15:0] w, input bit stall);
        exp_t got;
        int   n;
        accept(w);
        sb.push_back(model(w));
        n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        check("out_valid_rise", out_valid, 1);
        got = sb.pop_front();
        check("latency", n, got.lat);
        check("out_count", out_count, got.count);
        check("out_first_idx", out_first_idx, got.first);
        check("out_hit", out_hit, got.count != 0);
        if (stall) begin
            for (int c = 0; c < 5; c++) begin
                in_valid = 1'b1;
                in_data  = ~w;
                step();
                check("stall_out_valid", out_valid, 1);
                check("stall_in_ready", in_ready, 0);
                check("stall_out_count", out_count, got.count);
                check("stall_first_idx", out_first_idx, got.first);
                check("stall_out_hit", out_hit, got.count != 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        step();
        check("release_out_valid", out_valid, 0);
        check("release_busy", busy, 0);
        check("release_in_ready", in_ready, 1);
    endtask

    initial begin
        logic [15:0] w;
        aclr = 1'b1;
        step();
        step();
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_count", out_count, 0);
        check("rst_out_hit", out_hit, 0);
        check("rst_first_idx", out_first_idx, 0);
        aclr = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        run_word(16'h000F, 1'b0);
        run_word(16'hAAAA, 1'b0);
        run_word(16'hFFFF, 1'b0);
        run_word(16'hF000, 1'b0);
        run_word(16'h8001, 1'b0);
        for (int r = 0; r < 3; r++) begin
            w = 16'($urandom);
            run_word(w, 1'b0);
        end

        out_ready = 1'b0;
        run_word(16'h00F0, 1'b1);
        run_word(16'hFFFF, 1'b0);

        accept(16'h000F);
        repeat (7) step();
        check("mid_scan_busy", busy, 1);
        #2;
        aclr = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_in_ready", in_ready, 0);
        check("abort_out_count", out_count, 0);
        step();
        aclr = 1'b0;
        run_word(16'hFFFF, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/run_scan_ctrl.md
Name: run_scan_ctrl

Overview:
- Sequencing controller for the consecutive-equal-bit detector datapath.
- Accepts a parallel word over a valid/ready handshake and feeds it LSB-first, one bit per clock, into an internal run detector.
- The detector flags every bit that ends a run of RUN_LEN equal bits (zeros or ones, overlapping).
- Returns hit count and first-hit index over a second valid/ready handshake.
- Sits between a word producer (switch/bus register) and a result consumer (LED/display logic).

Parameters:
- WIDTH, 16, bits per scanned word; legal range is RUN_LEN to 64.
- RUN_LEN, 4, equal consecutive bits needed for a hit; legal range is 2 to WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- aclr  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  controller can accept a word.
- in_data  input  WIDTH  word to scan; bit 0 is scanned first.
- out_valid  output  1  result fields are valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  number of hit bits in the word, where CNT_W = clog2(WIDTH+1).
- out_first_idx  output  IDX_W  bit index of the first hit, where IDX_W = clog2(WIDTH); 0 if no hit.
- out_hit  output  1  out_count != 0.
- busy  output  1  state is SCAN or DONE.

Behaviour:
- Reset: aclr high forces IDLE immediately. Scan register, idx, count, first_idx and detector state clear to 0. out_valid=0, out_hit=0, busy=0, in_ready=0 while aclr is high.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - On a rising edge with in_valid&in_ready: capture in_data, set idx=0, clear count, first_idx and detector state, then go to SCAN.
- SCAN:
  - in_ready=0; in_valid is ignored.
  - On each edge, bit data[idx] is applied to the detector and idx increments.
  - Detector: the first bit of a word starts a run of length 1. A bit equal to the previous bit increments the run length, saturating at RUN_LEN. A bit different from the previous bit resets the run length to 1.
  - hit = (new run length == RUN_LEN). Runs overlap, so a 5th equal bit is also a hit.
  - On a hit, count increments. On the first hit of the word, first_idx is set to idx.
  - On the edge processing idx = WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; all out_* fields hold stable until out_ready is sampled high.
  - On the edge with out_ready high, go to IDLE.
  - There is no IDLE/DONE overlap: in_ready is low for the whole DONE cycle.
- Latency: out_valid rises WIDTH edges after the accepting edge.
- Throughput: one word per WIDTH+2 cycles at best.
- Width: count cannot overflow, since the maximum is WIDTH-RUN_LEN+1; no saturation logic is required.
- Reset mid-SCAN or mid-DONE discards the word; no partial result is ever presented.
- Outputs are registered, except in_ready and busy, which decode from the state register.

Optional Feature:
- Macro: RUN_SCAN_EARLY_EXIT_EN.
- Defined: SCAN exits to DONE on the edge that processes the first hit. out_count=1, out_first_idx=the hit index, and latency is first_idx+1 edges. A word with no hit still takes WIDTH edges.
- Undefined: the full word is always scanned and all hits are counted.

Decomposition:
- Package run_scan_pkg holds:
  - the state enum (IDLE, SCAN, DONE);
  - a clog2 helper function;
  - derived constants CNT_W and IDX_W.
- One sub-module, run_tracker:
  - inputs: clk, aclr, start (clears the run), bit_in, en;
  - output: hit;
  - internals: previous-bit and run-length registers.
- The controller owns the handshake, idx, count and first_idx.

Test Plan:
- WIDTH=16, RUN_LEN=4, in_data=16'h000F, out_ready=1 -> out_valid after 16 edges; out_count=10, out_first_idx=3, out_hit=1.
- in_data=16'hAAAA -> out_count=0, out_hit=0, out_first_idx=0.
- in_data=16'hFFFF -> out_count=13, out_first_idx=3.
- Hold out_ready=0 for 5 cycles in DONE while pulsing in_valid with a new word -> outputs stable, in_ready=0, new word not accepted. With out_ready=1 -> IDLE, then the new word is accepted.
- Assert aclr while SCAN is at idx=7 -> same-cycle IDLE, out_valid=0, busy=0. Next word 16'hFFFF -> out_count=13, with no carry-over from the aborted word.
- With RUN_SCAN_EARLY_EXIT_EN defined, in_data=16'h00F0 -> out_valid after 4 edges; out_count=1, out_first_idx=3.
